serialize_word_to_bit_stream: RTL and testbench

//   Parallel-to-serial front end for the bit-stream sequence detectors. Accepts WIDTH-bit

---
 rtl/serialize_pkg.sv | 19 +
 rtl/serialize_hold_buf.sv | 38 +++
 rtl/serialize_word_to_bit_stream.sv | 123 ++++++++++++
 tb/tb_serialize_word_to_bit_stream.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serialize_pkg.sv
// Shared types and helpers for the word-to-bit-stream serializer.
// The optional parity bit is enabled by defining SERIALIZE_PARITY_EN.
package serialize_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  // Number of serial bits per frame: the data bits, plus one parity bit when enabled.
  function automatic int frame_len(input int width);
`ifdef SERIALIZE_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/serialize_hold_buf.sv
// One-entry valid/ready holding register that decouples upstream acceptance
// from the serializer's load slot, so frames can run back to back.
module serialize_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (pop) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
    end
  end

  // NOTE: the payload register is deliberately left without reset; it is only
  // ever observed while valid is set, and valid is reset.
  always_ff @(posedge clk) begin
    if (push) begin
      data <= push_data;
    end
  end

  assign ready = ~valid;

endmodule

// File: rtl/serialize_word_to_bit_stream.sv
// Parallel-to-serial front end: words in over valid/ready, bits out MSB-first, one per
// clock, with IDLE_BIT in gaps. Define SERIALIZE_PARITY_EN to append an even-parity bit.
module serialize_word_to_bit_stream
  import serialize_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0,
  parameter int   CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             serial_bit,
  output logic             serial_act,
  output logic             serial_last,
  output logic [CNT_W-1:0] frame_count
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int BIT_W     = $clog2(FRAME_LEN);
  localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(FRAME_LEN - 1);

  state_t             state_q, state_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   frame_count_q, frame_count_d;

  logic               buf_valid;
  logic [WIDTH-1:0]   buf_data;
  logic               buf_push;
  logic               buf_pop;

  logic               accept;
  logic               at_last;
  logic               load;
  logic [WIDTH-1:0]   load_word;
  logic               data_bit;

  serialize_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data (up_data),
    .pop       (buf_pop),
    .valid     (buf_valid),
    .data      (buf_data),
    .ready     (up_ready)
  );

  // A load slot opens when idle or on the last bit; the buffered word has priority
  // over a word arriving this cycle, which then bypasses straight into the shifter.
  assign accept    = up_valid & up_ready;
  assign at_last   = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_IDX);
  assign load      = ((state_q == ST_IDLE) || at_last) && (buf_valid || accept);
  assign load_word = buf_valid ? buf_data : up_data;
  assign buf_pop   = load & buf_valid;
  assign buf_push  = accept & ~(load & ~buf_valid);

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    frame_count_d = frame_count_q;

    if (at_last) begin
      frame_count_d = frame_count_q + CNT_W'(1);
    end

    if (load) begin
      state_d   = ST_SHIFT;
      bit_cnt_d = '0;
      shift_d   = load_word;
    end else if (at_last) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_SHIFT) begin
      bit_cnt_d = bit_cnt_q + BIT_W'(1);
      shift_d   = shift_q << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

`ifdef SERIALIZE_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (load) begin
      parity_q <= ^load_word;
    end
  end

  // The parity bit occupies the slot after the last data bit.
  assign data_bit = (bit_cnt_q == BIT_W'(WIDTH)) ? parity_q : shift_q[WIDTH-1];
`else
  assign data_bit = shift_q[WIDTH-1];
`endif

  assign serial_act  = (state_q == ST_SHIFT);
  assign serial_last = at_last;
  assign serial_bit  = serial_act ? data_bit : IDLE_BIT;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_serialize_word_to_bit_stream.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared against a
// queue-of-expected-bits model of the serial stream.
module tb_serialize_word_to_bit_stream;

  localparam int   W     = 8;
  localparam int   CNT_W = 4;
  localparam logic IDLE  = 1'b0;
`ifdef SERIALIZE_PARITY_EN
  localparam int FL  = W + 1;
  localparam int FL6 = 7;
`else
  localparam int FL  = W;
  localparam int FL6 = 6;
`endif

  logic             clk;
  logic             rst;
  logic             up_valid;
  logic [W-1:0]     up_data;
  logic             up_ready;
  logic             serial_bit;
  logic             serial_act;
  logic             serial_last;
  logic [CNT_W-1:0] frame_count;

  logic             v6;
  logic [5:0]       d6;
  logic             ready6;
  logic             bit6;
  logic             act6;
  logic             last6;
  logic [15:0]      fc6;

  serialize_word_to_bit_stream #(
    .WIDTH (W), .IDLE_BIT (IDLE), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst (rst), .up_valid (up_valid), .up_data (up_data),
    .up_ready (up_ready), .serial_bit (serial_bit), .serial_act (serial_act),
    .serial_last (serial_last), .frame_count (frame_count)
  );

  serialize_word_to_bit_stream #(
    .WIDTH (6), .IDLE_BIT (IDLE), .CNT_W (16)
  ) dut6 (
    .clk (clk), .rst (rst), .up_valid (v6), .up_data (d6),
    .up_ready (ready6), .serial_bit (bit6), .serial_act (act6),
    .serial_last (last6), .frame_count (fc6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: every accepted word becomes its frame of {bit, is_last} entries,
  // queued in emission order. The stream is work-conserving, so the DUT must be active
  // exactly while this queue is non-empty, and the buffer is full exactly when more
  // than one frame's worth of bits is still pending.
  logic [1:0] exp_q[$];
  int         exp_frames  = 0;
  bit         model_ready = 1'b1;
  bit         last_acc    = 1'b0;
  bit         mon_en      = 1'b0;
  logic [1:0] mon_e;
  int         mon_sz;

  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back({w[i], (i == 0) && (FL == W)});
    if (FL != W) exp_q.push_back({^w, 1'b1});
  endtask

  always @(posedge clk) begin
    last_acc = 1'b0;
    if (rst) begin
      exp_q.delete();
      exp_frames = 0;
      mon_en     = 1'b1;
    end else if (mon_en && up_valid && model_ready) begin
      push_word(up_data);
      last_acc = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      mon_sz = exp_q.size();
      check("act", serial_act, mon_sz > 0);
      check("ready", up_ready, mon_sz <= FL);
      check("frames", frame_count, exp_frames % (1 << CNT_W));
      if (mon_sz > 0) begin
        mon_e = exp_q.pop_front();
        check("bit", serial_bit, mon_e[1]);
        check("last", serial_last, mon_e[0]);
        if (mon_e[0]) exp_frames++;
      end else begin
        check("idle_bit", serial_bit, IDLE);
        check("idle_last", serial_last, 1'b0);
      end
      model_ready = (mon_sz <= FL);
    end
  end

  // Offer a word and hold it until the model says it was taken; up_valid stays high
  // so a following call continues back to back.
  task automatic send(input logic [W-1:0] w);
    int n = 0;
    up_valid = 1'b1;
    up_data  = w;
    do begin
      @(negedge clk);
      n++;
    end while (!last_acc && n < 100);
    check("send_accept", last_acc, 1'b1);
  endtask

  logic [5:0] det6;
  logic [5:0] w6;
  logic       exp6;

  initial begin
    rst      = 1'b1;
    up_valid = 1'b1;
    up_data  = 8'h5A;
    v6       = 1'b1;
    d6       = 6'h2A;
    repeat (3) @(negedge clk);
    check("rst_act", serial_act, 1'b0);
    check("rst_bit", serial_bit, IDLE);
    check("rst_fc", frame_count, 0);
    check("rst_act6", act6, 1'b0);
    rst      = 1'b0;
    up_valid = 1'b0;
    v6       = 1'b0;

    // WIDTH=6 frame into an idle block, observed by a 6-bit "110011" detector.
    @(negedge clk);
    w6   = 6'b110011;
    det6 = '0;
    v6   = 1'b1;
    d6   = w6;
    @(negedge clk);
    v6 = 1'b0;
    d6 = 6'b000000;
    for (int i = 0; i < FL6; i++) begin
      exp6 = (i < 6) ? w6[5 - i] : ^w6;
      check("w6_act", act6, 1'b1);
      check("w6_bit", bit6, exp6);
      check("w6_last", last6, i == FL6 - 1);
      if (i < 6) det6 = {det6[4:0], bit6};
      @(negedge clk);
    end
    check("w6_detect", det6, w6);
    check("w6_idle_act", act6, 1'b0);
    check("w6_idle_bit", bit6, IDLE);
    check("w6_fc", fc6, 1);

    // Two words back to back: one contiguous stream, two frames counted.
    send(8'hA5);
    send(8'h3C);
    up_valid = 1'b0;
    repeat (2 * FL + 2) @(negedge clk);
    check("b2b_fc", frame_count, 2);

    // Three words offered continuously: the buffer fills and throttles upstream.
    send(8'h11);
    send(8'h22);
    send(8'h33);
    up_valid = 1'b0;
    repeat (3 * FL + 2) @(negedge clk);
    check("three_fc", frame_count, 5);

    send(8'h07);
    up_valid = 1'b0;
    repeat (FL + 2) @(negedge clk);

    // Reset at bit 3 of 8'hFF with a second word waiting in the buffer.
    send(8'hFF);
    send(8'h81);
    up_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_act", serial_act, 1'b1);
    check("mid_full", up_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_act", serial_act, 1'b0);
    check("mid_rst_ready", up_ready, 1'b1);
    check("mid_rst_fc", frame_count, 0);
    repeat (2 * FL) @(negedge clk);

    // Randomized traffic with occasional resets; long enough to wrap frame_count.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 399) == 0);
      up_valid = ($urandom_range(0, 3) != 0);
      up_data  = W'($urandom);
      @(negedge clk);
    end
    rst      = 1'b0;
    up_valid = 1'b0;
    repeat (3 * FL) @(negedge clk);
    check("drain_act", serial_act, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
